alu_arbiter: RTL and testbench

Two-requester scheduler that shares the single combinational 8-bit ALU of the microcontroller between the core execute stage (requester 0) and the auxiliary engine (requester 1). It arbitrates round-robin, registers the winning operation's operands and mode, drives the ALU for one execute cycle, and captures result and flags. It returns them on a shared response channel tagged with the requester id. It also owns the architectural flags register, which is fed back to the ALU as its carry-in flag vector.

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter request/response bundle.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_mode0;
  logic [3:0] req_mode1;
  logic [7:0] req_a0;
  logic [7:0] req_a1;
  logic [7:0] req_b0;
  logic [7:0] req_b1;
  logic [1:0] req_lock;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [7:0] resp_data;
  logic [3:0] resp_flags;

  modport master (
    output req_valid,
    output req_mode0,
    output req_mode1,
    output req_a0,
    output req_a1,
    output req_b0,
    output req_b1,
    output req_lock,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_id,
    input  resp_data,
    input  resp_flags
  );

  modport slave (
    input  req_valid,
    input  req_mode0,
    input  req_mode1,
    input  req_a0,
    input  req_a1,
    input  req_b0,
    input  req_b1,
    input  req_lock,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_id,
    output resp_data,
    output resp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-requester scheduler for the shared 8-bit ALU.
// Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic [7:0]   alu_op1,
  output logic [7:0]   alu_op2,
  output logic [3:0]   alu_mode,
  output logic         alu_en,
  output logic [3:0]   alu_cflags,
  input  logic [7:0]   alu_out,
  input  logic [3:0]   alu_flags
);

`ifdef ALU_ARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       id;
  } op_t;

  logic [1:0] state_q;
  op_t        op_q;
  logic       last_id_q;
  logic       lock_q;
  logic [3:0] flags_q;
  logic [7:0] rdata_q;
  logic [3:0] rflags_q;

  logic       grant_vld;
  logic       grant_id;
  logic       grant_lock;
  op_t        grant_op;
  logic       accept;

  // Pick the winner: locked owner, else round-robin on a tie.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    unique case (1'b1)
      lock_q: begin
        grant_id  = op_q.id;
        grant_vld = bus.req_valid[op_q.id];
      end
      (!lock_q && bus.req_valid == 2'b11): begin
        grant_id  = ~last_id_q;
        grant_vld = 1'b1;
      end
      (!lock_q && bus.req_valid == 2'b10): begin
        grant_id  = 1'b1;
        grant_vld = 1'b1;
      end
      (!lock_q && bus.req_valid == 2'b01): begin
        grant_id  = 1'b0;
        grant_vld = 1'b1;
      end
      default: ;
    endcase
  end

  // Select the winner's operation fields.
  always_comb begin
    grant_op      = '0;
    grant_op.id   = grant_id;
    grant_op.mode = grant_id ? bus.req_mode1 : bus.req_mode0;
    grant_op.a    = grant_id ? bus.req_a1 : bus.req_a0;
    grant_op.b    = grant_id ? bus.req_b1 : bus.req_b0;
    grant_lock    = LOCK_EN & bus.req_lock[grant_id];
  end

  assign accept = (state_q == S_IDLE) & grant_vld;

  assign bus.req_ready = !accept ? 2'b00 :
                         grant_id ? 2'b10 : 2'b01;

  // Sequencer: accept, execute one cycle, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      last_id_q <= 1'b0;
      lock_q    <= 1'b0;
      flags_q   <= 4'h0;
      rdata_q   <= 8'h00;
      rflags_q  <= 4'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= grant_op;
            lock_q  <= grant_lock;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          rdata_q  <= alu_out;
          rflags_q <= alu_flags;
          flags_q  <= alu_flags;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            if (!lock_q) begin
              last_id_q <= op_q.id;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_op1    = op_q.a;
  assign alu_op2    = op_q.b;
  assign alu_mode   = op_q.mode;
  assign alu_en     = (state_q == S_EXEC);
  assign alu_cflags = flags_q;

  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_id    = op_q.id;
  assign bus.resp_data  = rdata_q;
  assign bus.resp_flags = rflags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small add/sub ALU model.
// Expected results are hand-computed constants.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic [3:0] alu_mode;
  logic       alu_en;
  logic [3:0] alu_cflags;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_mode   (alu_mode),
    .alu_en     (alu_en),
    .alu_cflags (alu_cflags),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags)
  );

  // mode 1 = subtract (C = no borrow), anything else = add
  logic [8:0] s;
  logic       ov;
  always_comb begin
    s  = '0;
    ov = 1'b0;
    if (alu_mode == 4'd1) begin
      s  = {1'b0, alu_op1} + {1'b0, ~alu_op2} + 9'd1;
      ov = (alu_op1[7] != alu_op2[7]) && (s[7] != alu_op1[7]);
    end else begin
      s  = {1'b0, alu_op1} + {1'b0, alu_op2};
      ov = (alu_op1[7] == alu_op2[7]) && (s[7] != alu_op1[7]);
    end
    alu_out   = s[7:0];
    alu_flags = {(s[7:0] == 8'h00), s[8], s[7], ov};
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int ncyc = 0;
  int g_id[$];
  int g_cyc[$];

  // Record every handshake that the next rising edge will take.
  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(ncyc);
        end
      end
    end
  end

  logic       ex_en;
  logic [3:0] ex_cf;
  logic [7:0] ex_op1;
  logic       ex_rv;
  logic       r_valid;
  logic       r_id;
  logic [7:0] r_data;
  logic [3:0] r_flags;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 2'b00;
    bus.req_lock   = 2'b00;
    bus.req_mode0  = 4'h0;
    bus.req_mode1  = 4'h0;
    bus.req_a0     = 8'h00;
    bus.req_a1     = 8'h00;
    bus.req_b0     = 8'h00;
    bus.req_b1     = 8'h00;
    bus.resp_ready = 1'b1;
  endtask

  task automatic run_op(input int id, input logic [3:0] mode,
                        input logic [7:0] a, input logic [7:0] b,
                        input int stall);
    bit got;
    tick();
    if (id == 1) begin
      bus.req_mode1 = mode;
      bus.req_a1    = a;
      bus.req_b1    = b;
    end else begin
      bus.req_mode0 = mode;
      bus.req_a0    = a;
      bus.req_b0    = b;
    end
    bus.req_valid[id] = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        got = 1;
        break;
      end
    end
    check("accept", 32'(got), 32'd1);
    tick();
    bus.req_valid[id] = 1'b0;
    bus.resp_ready    = (stall == 0);
    @(negedge clk);
    ex_en  = alu_en;
    ex_cf  = alu_cflags;
    ex_op1 = alu_op1;
    ex_rv  = bus.resp_valid;
    @(negedge clk);
    r_valid = bus.resp_valid;
    r_id    = bus.resp_id;
    r_data  = bus.resp_data;
    r_flags = bus.resp_flags;
    if (stall > 0) begin
      bus.req_valid[1-id] = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        check("stall_valid", 32'(bus.resp_valid), 32'd1);
        check("stall_data", 32'(bus.resp_data), 32'(r_data));
        check("stall_flags", 32'(bus.resp_flags), 32'(r_flags));
        check("stall_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid[1-id] = 1'b0;
      bus.resp_ready      = 1'b1;
    end
    tick();
    check("resp_drop", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 60 && g_id.size() < n; k++) begin
      tick();
      if (g_id.size() >= 1) bus.req_lock[0] = 1'b0;
    end
    check("grant_count", 32'(g_id.size()), 32'(n));
    bus.req_valid = 2'b00;
    repeat (4) tick();
  endtask

  int exp_g[3];
  int bad_rv;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'h00);
    check("rst_resp_flags", 32'(bus.resp_flags), 32'h0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_cflags", 32'(alu_cflags), 32'h0);
    check("rst_alu_en", 32'(alu_en), 32'd0);
    check("rst_op1", 32'(alu_op1), 32'h00);
    check("rst_mode", 32'(alu_mode), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;

    run_op(0, 4'b0000, 8'h7F, 8'h01, 0);
    check("op1_exec_en", 32'(ex_en), 32'd1);
    check("op1_exec_a", 32'(ex_op1), 32'h7F);
    check("op1_exec_rv", 32'(ex_rv), 32'd0);
    check("op1_latency", 32'(r_valid), 32'd1);
    check("op1_id", 32'(r_id), 32'd0);
    check("op1_data", 32'(r_data), 32'h80);
    check("op1_flags", 32'(r_flags), 32'b0011);

    run_op(1, 4'b0000, 8'hFF, 8'h01, 0);
    check("op2_id", 32'(r_id), 32'd1);
    check("op2_data", 32'(r_data), 32'h00);
    check("op2_flags", 32'(r_flags), 32'b1100);
    check("op2_cflags", 32'(alu_cflags), 32'b1100);

    run_op(0, 4'b0001, 8'h05, 8'h03, 5);
    check("op3_exec_cf", 32'(ex_cf), 32'b1100);
    check("op3_data", 32'(r_data), 32'h02);
    check("op3_flags", 32'(r_flags), 32'b0100);
    check("op3_cflags", 32'(alu_cflags), 32'b0100);
    check("op3_idle_en", 32'(alu_en), 32'd0);
    check("op3_hold_op1", 32'(alu_op1), 32'h05);

    g_id.delete();
    g_cyc.delete();
    bus.req_mode0 = 4'h0;
    bus.req_mode1 = 4'h0;
    bus.req_valid = 2'b11;
    wait_grants(4);
    if (g_id.size() >= 4) begin
      check("rr_g0", 32'(g_id[0]), 32'd1);
      check("rr_g1", 32'(g_id[1]), 32'd0);
      check("rr_g2", 32'(g_id[2]), 32'd1);
      check("rr_g3", 32'(g_id[3]), 32'd0);
      for (int i = 1; i < 4; i++)
        check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end

`ifdef ALU_ARB_LOCK_EN
    run_op(1, 4'b0000, 8'h01, 8'h01, 0);
    exp_g[0] = 0;
    exp_g[1] = 0;
    exp_g[2] = 1;
`else
    exp_g[0] = 1;
    exp_g[1] = 0;
    exp_g[2] = 1;
`endif
    g_id.delete();
    g_cyc.delete();
    tick();
    bus.req_lock  = 2'b01;
    bus.req_valid = 2'b11;
    wait_grants(3);
    if (g_id.size() >= 3) begin
      check("lock_g0", 32'(g_id[0]), 32'(exp_g[0]));
      check("lock_g1", 32'(g_id[1]), 32'(exp_g[1]));
      check("lock_g2", 32'(g_id[2]), 32'(exp_g[2]));
    end

    idle_inputs();
    tick();
    bus.req_a0        = 8'h10;
    bus.req_b0        = 8'h20;
    bus.req_valid[0]  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready[0]) break;
    end
    tick();
    bus.req_valid[0] = 1'b0;
    check("mid_in_exec", 32'(alu_en), 32'd1);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_en", 32'(alu_en), 32'd0);
    check("mid_rst_op1", 32'(alu_op1), 32'h00);
    check("mid_rst_data", 32'(bus.resp_data), 32'h00);
    check("mid_rst_flags", 32'(bus.resp_flags), 32'h0);
    check("mid_rst_cflags", 32'(alu_cflags), 32'h0);
    tick();
    rst_n  = 1'b1;
    bad_rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) bad_rv++;
    end
    check("mid_rst_no_resp", 32'(bad_rv), 32'd0);

    run_op(1, 4'b0000, 8'h22, 8'h11, 0);
    check("post_rst_id", 32'(r_id), 32'd1);
    check("post_rst_data", 32'(r_data), 32'h33);
    check("post_rst_flags", 32'(r_flags), 32'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
